// File: rtl/mod_data_source_if.sv
// Configuration and symbol-output bundle of the modulator data source.
interface mod_data_source_if #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned PAT_WIDTH = 32,
  parameter int unsigned RUN_WIDTH = 5
);
  localparam int unsigned IDX_WIDTH = $clog2(PAT_WIDTH);

  logic                 load;
  logic                 enable;
  logic [DIV_WIDTH-1:0] divider;
  logic [1:0]           mode;
  logic [2:0]           pnOrder;
  logic [PAT_WIDTH-1:0] pattern;
  logic [IDX_WIDTH-1:0] patternLen;
  logic [RUN_WIDTH-1:0] runLimit;
  logic                 extData;
  logic                 modClkOut;
  logic                 symEn;
  logic                 dataOut;
  logic [1:0]           ternary;

  modport master (
    output load, enable, divider, mode, pnOrder, pattern, patternLen, runLimit, extData,
    input  modClkOut, symEn, dataOut, ternary
  );

  modport slave (
    input  load, enable, divider, mode, pnOrder, pattern, patternLen, runLimit, extData,
    output modClkOut, symEn, dataOut, ternary
  );
endinterface

// File: rtl/mod_data_source.sv
// Bit/symbol source for the SOQPSK/FM modulators: bit-clock divider, PN /
// pattern / external / alternating source, zero-run limiter and SOQPSK
// ternary precoder with a one-cycle symbol strobe.
module mod_data_source #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned PAT_WIDTH = 32,
  parameter int unsigned RUN_WIDTH = 5
) (
  input  logic            clk,
  input  logic            reset,
  mod_data_source_if.slave bus
);
  localparam int unsigned IDX_WIDTH  = $clog2(PAT_WIDTH);
  localparam int unsigned LFSR_WIDTH = 23;

  logic [DIV_WIDTH-1:0]  divCnt;
  logic                  modClk;
  logic                  symEnR;
  logic                  dataR;
  logic [1:0]            ternR;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [IDX_WIDTH-1:0]  patIdx;
  logic                  altBit;
  logic [RUN_WIDTH-1:0]  zeroCount;
  logic                  aM1;      // a[k-1], 1 means +1
  logic                  aM2;      // a[k-2], 1 means +1
  logic                  kOdd;

  logic                  symEdge_c;
  logic                  fb_c;
  logic [LFSR_WIDTH-1:0] lfsrNext_c;
  logic [IDX_WIDTH-1:0]  patSel_c;
  logic                  srcBit_c;
  logic                  forceOne_c;
  logic                  bit_c;
  logic [RUN_WIDTH-1:0]  zeroNext_c;
  logic                  neg_c;
  logic [1:0]            ternNext_c;

  assign bus.modClkOut = modClk;
  assign bus.symEn     = symEnR;
  assign bus.dataOut   = dataR;
  assign bus.ternary   = ternR;

  // Symbol edge is the cycle where the bit clock falls.
  assign symEdge_c = modClk && (divCnt == '0);

  // LFSR step for the selected order; feedback enters at bit n-1.
  always_comb begin
    lfsrNext_c = lfsr >> 1;
    fb_c       = lfsr[0] ^ lfsr[4];
    case (bus.pnOrder)
      3'd1:    begin fb_c = lfsr[0] ^ lfsr[2]; lfsrNext_c[10] = fb_c; end
      3'd2:    begin fb_c = lfsr[0] ^ lfsr[1]; lfsrNext_c[14] = fb_c; end
      3'd3:    begin fb_c = lfsr[0] ^ lfsr[3]; lfsrNext_c[16] = fb_c; end
      3'd4:    begin fb_c = lfsr[0] ^ lfsr[5]; lfsrNext_c[22] = fb_c; end
      default: begin fb_c = lfsr[0] ^ lfsr[4]; lfsrNext_c[8]  = fb_c; end
    endcase
  end

  // Source selection, run limiter and precoder for the next symbol.
  always_comb begin
    patSel_c = bus.patternLen - patIdx;
    case (bus.mode)
      2'd0:    srcBit_c = lfsr[0];
      2'd1:    srcBit_c = bus.pattern[patSel_c];
      2'd2:    srcBit_c = bus.extData;
      default: srcBit_c = altBit;
    endcase
    forceOne_c = (bus.runLimit != '0) && (zeroCount == bus.runLimit);
    bit_c      = forceOne_c | srcBit_c;
    if (bit_c) begin
      zeroNext_c = '0;
    end else if (zeroCount != '1) begin
      zeroNext_c = zeroCount + RUN_WIDTH'(1);
    end else begin
      zeroNext_c = zeroCount;
    end
    // alpha = (-1)^(k+1) * a[k-1] * a[k] whenever a[k] != a[k-2]
    neg_c = ~(kOdd ^ aM1 ^ bit_c);
    if (bit_c == aM2) begin
      ternNext_c = 2'b00;
    end else begin
      ternNext_c = neg_c ? 2'b11 : 2'b01;
    end
  end

  // Bit-clock divider; reload value picked up only at terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCnt <= bus.divider;
      modClk <= 1'b0;
    end else if (divCnt == '0) begin
      divCnt <= bus.divider;
      modClk <= ~modClk;
    end else begin
      divCnt <= divCnt - DIV_WIDTH'(1);
    end
  end

  // Data path: load reseeds, enabled symbol edges emit and advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      symEnR    <= 1'b0;
      dataR     <= 1'b0;
      ternR     <= 2'b00;
      lfsr      <= '1;
      patIdx    <= '0;
      altBit    <= 1'b1;
      zeroCount <= '0;
      aM1       <= 1'b1;
      aM2       <= 1'b1;
      kOdd      <= 1'b0;
    end else begin
      symEnR <= 1'b0;
      if (!bus.enable) begin
        ternR <= 2'b00;
      end
      if (bus.load) begin
        lfsr      <= '1;
        patIdx    <= '0;
        altBit    <= 1'b1;
        zeroCount <= '0;
        aM1       <= 1'b1;
        aM2       <= 1'b1;
        kOdd      <= 1'b0;
      end else if (symEdge_c && bus.enable) begin
        symEnR    <= 1'b1;
        dataR     <= bit_c;
        ternR     <= ternNext_c;
        zeroCount <= zeroNext_c;
        aM2       <= aM1;
        aM1       <= bit_c;
        kOdd      <= ~kOdd;
        case (bus.mode)
          2'd0:    lfsr <= lfsrNext_c;
          2'd1:    patIdx <= (patIdx >= bus.patternLen) ? '0 : patIdx + IDX_WIDTH'(1);
          2'd3:    altBit <= ~altBit;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mod_data_source.sv
// Scoreboard bench for mod_data_source: stimulus pushes expected symbols,
// a negedge monitor pops and compares on every symEn.
module tb_mod_data_source;
  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned PAT_WIDTH = 32;
  localparam int unsigned RUN_WIDTH = 5;
  localparam int unsigned DIV       = 3;
  localparam int          BITCLK    = 2 * (DIV + 1);

  logic clk = 1'b0;
  logic reset;

  mod_data_source_if #(.DIV_WIDTH(DIV_WIDTH), .PAT_WIDTH(PAT_WIDTH), .RUN_WIDTH(RUN_WIDTH)) bus ();

  mod_data_source #(.DIV_WIDTH(DIV_WIDTH), .PAT_WIDTH(PAT_WIDTH), .RUN_WIDTH(RUN_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       d;
    logic [1:0] t;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   onesSeen    = 0;
  int   hm1, hm2, kk;
  bit   pnBits[0:599];

  // Reference precoder in integer arithmetic.
  function automatic logic [1:0] precode(input bit b);
    int a, al;
    a   = b ? 1 : -1;
    al  = ((kk % 2) == 1 ? 1 : -1) * hm1 * (a - hm2) / 2;
    hm2 = hm1;
    hm1 = a;
    kk  = kk + 1;
    if (al == 1)  return 2'b01;
    if (al == -1) return 2'b11;
    return 2'b00;
  endfunction

  task automatic resetModel();
    hm1 = 1;
    hm2 = 1;
    kk  = 0;
  endtask

  task automatic pushBit(input bit b);
    exp_t e;
    e.d = b;
    e.t = precode(b);
    sbq.push_back(e);
  endtask

  // PN sequence as a recurrence: b[j] = b[j-n] ^ b[j-m], seeded with n ones.
  task automatic genPn(input int n, input int m, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      pnBits[i] = (i < n) ? 1'b1 : (pnBits[i-n] ^ pnBits[i-m]);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drain(input string name, input int items);
    int c;
    c = 0;
    while (sbq.size() != 0 && c < (items + 4) * BITCLK) begin
      @(negedge clk);
      c++;
    end
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout with %0d symbols outstanding, expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic pulseLoad();
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    resetModel();
  endtask

  task automatic waitFirstSym(input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (bus.symEn !== 1'b1 && c < 100);
    check(name, c, BITCLK);
  endtask

  // Monitor: every symEn must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.symEn === 1'b1) begin
      exp_t e;
      if (bus.dataOut === 1'b1) onesSeen++;
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL sym_unexpected: got symEn=1 data=%0d tern=%b, expected no symbol", bus.dataOut, bus.ternary);
      end else begin
        e = sbq.pop_front();
        if (bus.dataOut !== e.d || bus.ternary !== e.t) begin
          miscompares++;
          $display("FAIL sym_out: got data=%0d tern=%b expected data=%0d tern=%b", bus.dataOut, bus.ternary, e.d, e.t);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int c, hi, ones0;
    int ns[6] = '{9, 11, 15, 17, 23, 9};
    int ms[6] = '{5, 9, 14, 14, 18, 5};
    bit ext[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bit lim[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    reset          = 1'b1;
    bus.load       = 1'b0;
    bus.enable     = 1'b1;
    bus.divider    = DIV_WIDTH'(DIV);
    bus.mode       = 2'd3;
    bus.pnOrder    = 3'd0;
    bus.pattern    = '0;
    bus.patternLen = '0;
    bus.runLimit   = '0;
    bus.extData    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_modclk", int'(bus.modClkOut), 0);
    check("rst_symen",  int'(bus.symEn), 0);
    check("rst_data",   int'(bus.dataOut), 0);
    check("rst_tern",   int'(bus.ternary), 0);

    // Alternating source, period and duty of the bit clock.
    resetModel();
    for (int i = 0; i < 8; i++) pushBit(i % 2 == 0);
    reset = 1'b0;
    waitFirstSym("first_sym_alt");
    c  = 0;
    hi = 0;
    do begin
      @(negedge clk);
      c++;
      if (bus.modClkOut === 1'b1) hi++;
    end while (bus.symEn !== 1'b1 && c < 100);
    check("sym_period", c, BITCLK);
    check("modclk_high", hi, BITCLK / 2);
    drain("alt", 8);

    // PN9 over a full period and the start of the repeat.
    bus.mode    = 2'd0;
    bus.pnOrder = 3'd0;
    pulseLoad();
    genPn(9, 5, 520);
    ones0 = onesSeen;
    for (int i = 0; i < 511; i++) pushBit(pnBits[i]);
    drain("pn9_period", 511);
    check("pn9_ones", onesSeen - ones0, 256);
    for (int i = 511; i < 520; i++) pushBit(pnBits[i]);
    drain("pn9_repeat", 9);

    // Enable low for three bit periods mid-PN9, then resume.
    pulseLoad();
    for (int i = 0; i < 20; i++) pushBit(pnBits[i]);
    drain("pn9_pre_dis", 20);
    bus.enable = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3 * BITCLK; i++) begin
      @(negedge clk);
      check("enable_low", {bus.symEn, bus.dataOut, bus.ternary}, {1'b0, pnBits[19], 2'b00});
    end
    for (int i = 20; i < 40; i++) pushBit(pnBits[i]);
    bus.enable = 1'b1;
    drain("pn9_resume", 20);

    // Remaining orders, including an out-of-range order treated as PN9.
    for (int o = 1; o < 6; o++) begin
      bus.pnOrder = 3'(o);
      pulseLoad();
      genPn(ns[o], ms[o], 40);
      for (int i = 0; i < 40; i++) pushBit(pnBits[i]);
      drain("pn_order", 40);
    end

    // Pattern 1000 repeating (bit 3 and bit 31 set so MSB-first reads agree).
    bus.mode       = 2'd1;
    bus.pattern    = 32'h8000_0008;
    bus.patternLen = 5'd3;
    pulseLoad();
    for (int i = 0; i < 8; i++) pushBit(i % 4 == 0);
    drain("pattern", 8);

    // Zero-run limit of 2 forces a one after every second zero.
    bus.runLimit = 5'd2;
    pulseLoad();
    for (int i = 0; i < 8; i++) pushBit(lim[i]);
    drain("run_limit", 8);
    bus.runLimit = '0;

    // All-ones pattern gives a constant zero symbol.
    bus.pattern = '1;
    pulseLoad();
    for (int i = 0; i < 6; i++) pushBit(1'b1);
    drain("all_ones", 6);

    // External data sampled at each symbol edge.
    bus.mode = 2'd2;
    pulseLoad();
    for (int i = 0; i < 8; i++) begin
      bus.extData = ext[i];
      pushBit(ext[i]);
      drain("external", 1);
    end

    // Reset mid-pattern returns outputs to reset values and restarts.
    bus.mode    = 2'd1;
    bus.pattern = 32'h8000_0008;
    pulseLoad();
    for (int i = 0; i < 5; i++) pushBit(i % 4 == 0);
    drain("pat_pre_rst", 5);
    reset = 1'b1;
    #1;
    check("midrst_modclk", int'(bus.modClkOut), 0);
    check("midrst_symen",  int'(bus.symEn), 0);
    check("midrst_data",   int'(bus.dataOut), 0);
    check("midrst_tern",   int'(bus.ternary), 0);
    repeat (2) @(negedge clk);
    resetModel();
    for (int i = 0; i < 4; i++) pushBit(i % 4 == 0);
    reset = 1'b0;
    waitFirstSym("first_sym_rst");
    drain("pat_post_rst", 4);

    // Load coincident with a symbol edge suppresses that symbol.
    for (int i = 0; i < 5; i++) pushBit(i % 4 == 0);
    drain("pat_pre_load", 5);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (bus.modClkOut !== 1'b1 && c < 100);
    repeat (DIV) @(negedge clk);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    resetModel();
    check("load_edge_modclk", int'(bus.modClkOut), 0);
    check("load_edge_symen",  int'(bus.symEn), 0);
    for (int i = 0; i < 4; i++) pushBit(i % 4 == 0);
    drain("pat_post_load", 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
